// File: rtl/note_scheduler.sv
// Note scheduler: queues {tone code, duration} entries and plays them in order on the
// tone divider, inserting a silent gap and a note_done pulse after every note.
module note_scheduler #(
  parameter int unsigned BEAT_DIV   = 12500000,
  parameter int unsigned GAP_CYCLES = 500000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        iclk,
  input  logic        irst_n,
  input  logic        in_valid,
  input  logic [3:0]  in_code,
  input  logic [3:0]  in_dur,
  output logic        in_ready,
  input  logic        stop,
  output logic [31:0] half_period,
  output logic        tone_en,
  output logic        busy,
  output logic        note_done
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

  state_t           state_q, state_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [7:0]       mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [3:0]       cur_code_q, cur_code_d;
  logic [3:0]       cur_dur_q, cur_dur_d;
  logic [3:0]       beats_left_q, beats_left_d;
  logic [31:0]      beat_cnt_q, beat_cnt_d;
  logic [31:0]      gap_cnt_q, gap_cnt_d;
  logic [31:0]      half_period_q, half_period_d;
  logic             tone_en_q, tone_en_d;
  logic             busy_q, busy_d;
  logic             note_done_q, note_done_d;
  logic             push, pop;
  logic [31:0]      hp_lut;

  function automatic logic [31:0] tone_hp(input logic [3:0] code);
    case (code)
      4'd1:    return 32'd95556;
      4'd2:    return 32'd85131;
      4'd3:    return 32'd75843;
      4'd4:    return 32'd71586;
      4'd5:    return 32'd63776;
      4'd6:    return 32'd56818;
      4'd7:    return 32'd50619;
      4'd8:    return 32'd47778;
      default: return '0;
    endcase
  endfunction

  assign hp_lut   = tone_hp(cur_code_q);
  assign in_ready = (count_q < CNT_W'(FIFO_DEPTH));

  always_comb begin
    state_d       = state_q;
    mem_d         = mem_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    cur_code_d    = cur_code_q;
    cur_dur_d     = cur_dur_q;
    beats_left_d  = beats_left_q;
    beat_cnt_d    = beat_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    half_period_d = half_period_q;
    tone_en_d     = tone_en_q;
    note_done_d   = 1'b0;
    pop           = 1'b0;
    push          = in_valid && in_ready;

    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (cur_dur_q == '0) begin
          if (count_q != '0) pop = 1'b1;
          else               state_d = IDLE;
        end else begin
          half_period_d = hp_lut;
          tone_en_d     = (hp_lut != '0);
          beats_left_d  = cur_dur_q;
          beat_cnt_d    = '0;
          state_d       = PLAY;
        end
      end
      PLAY: begin
        if (beat_cnt_q == 32'(BEAT_DIV - 1)) begin
          beat_cnt_d   = '0;
          beats_left_d = beats_left_q - 4'd1;
          if (beats_left_q == 4'd1) begin
            state_d     = GAP;
            tone_en_d   = 1'b0;
            gap_cnt_d   = '0;
            note_done_d = (GAP_CYCLES == 0);
          end
        end else begin
          beat_cnt_d = beat_cnt_q + 32'd1;
        end
      end
      GAP: begin
        // GAP_CYCLES silent cycles, then one more cycle carrying note_done before the next pop
        if (gap_cnt_q == 32'(GAP_CYCLES)) begin
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = LOAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_cnt_d   = gap_cnt_q + 32'd1;
          note_done_d = (gap_cnt_d == 32'(GAP_CYCLES));
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      cur_code_d = mem_q[rd_ptr_q][7:4];
      cur_dur_d  = mem_q[rd_ptr_q][3:0];
      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
    end
    if (push) begin
      mem_d[wr_ptr_q] = {in_code, in_dur};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    if (stop) begin
      state_d       = IDLE;
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
      count_d       = '0;
      half_period_d = '0;
      tone_en_d     = 1'b0;
      note_done_d   = 1'b0;
    end

    busy_d = (state_d != IDLE) || (count_d != '0);
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_q       <= IDLE;
      mem_q         <= '{default: '0};
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      cur_code_q    <= '0;
      cur_dur_q     <= '0;
      beats_left_q  <= '0;
      beat_cnt_q    <= '0;
      gap_cnt_q     <= '0;
      half_period_q <= '0;
      tone_en_q     <= 1'b0;
      busy_q        <= 1'b0;
      note_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_q         <= mem_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      cur_code_q    <= cur_code_d;
      cur_dur_q     <= cur_dur_d;
      beats_left_q  <= beats_left_d;
      beat_cnt_q    <= beat_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      half_period_q <= half_period_d;
      tone_en_q     <= tone_en_d;
      busy_q        <= busy_d;
      note_done_q   <= note_done_d;
    end
  end

  assign half_period = half_period_q;
  assign tone_en     = tone_en_q;
  assign busy        = busy_q;
  assign note_done   = note_done_q;

endmodule

// File: tb/tb_note_scheduler.sv
// Bench for note_scheduler: a timestamp-based note schedule model checked every cycle,
// directed scenarios with literal expectations, then randomized push/stop traffic.
module tb_note_scheduler;

  localparam int BEAT  = 4;
  localparam int GAPC  = 2;
  localparam int DEPTH = 4;

  logic        iclk     = 1'b0;
  logic        irst_n   = 1'b0;
  logic        in_valid = 1'b0;
  logic        stop     = 1'b0;
  logic [3:0]  in_code  = '0;
  logic [3:0]  in_dur   = '0;
  logic        in_ready, tone_en, busy, note_done;
  logic [31:0] half_period;

  int n_tests = 0, n_fail = 0;
  int nd_pulses = 0, ten_cycles = 0, low_run = 0, last_low = 0;

  note_scheduler #(
    .BEAT_DIV  (BEAT),
    .GAP_CYCLES(GAPC),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .iclk       (iclk),
    .irst_n     (irst_n),
    .in_valid   (in_valid),
    .in_code    (in_code),
    .in_dur     (in_dur),
    .in_ready   (in_ready),
    .stop       (stop),
    .half_period(half_period),
    .tone_en    (tone_en),
    .busy       (busy),
    .note_done  (note_done)
  );

  always #5 iclk = ~iclk;

  // Reference: each popped note becomes a set of absolute edge timestamps.
  int          tone_tab [16] = '{0, 95556, 85131, 75843, 71586, 63776, 56818, 50619, 47778,
                                 0, 0, 0, 0, 0, 0, 0};
  int          m_code [$];
  int          m_dur  [$];
  longint      e = 0, free_at = 0, set_at = -1, clr_at = -1, nd_at = -1;
  logic [31:0] set_hp = '0, m_hp = '0;
  logic        set_ten = 1'b0, m_ten = 1'b0, m_nd = 1'b0;
  int          pre = 0, pc = 0, pd = 0;

  initial begin
    forever begin
      @(posedge iclk or negedge irst_n);
      if (!irst_n) begin
        m_code.delete(); m_dur.delete();
        m_hp = '0; m_ten = 1'b0; m_nd = 1'b0;
        set_at = -1; clr_at = -1; nd_at = -1; free_at = e;
      end else begin
        e++;
        pre = m_code.size();
        if (stop) begin
          m_code.delete(); m_dur.delete();
          m_hp = '0; m_ten = 1'b0; m_nd = 1'b0;
          set_at = -1; clr_at = -1; nd_at = -1; free_at = e;
        end else begin
          m_nd = (e == nd_at);
          if (e == set_at) begin m_hp = set_hp; m_ten = set_ten; end
          if (e == clr_at) m_ten = 1'b0;
          if (e >= free_at && pre > 0) begin
            pc = m_code.pop_front();
            pd = m_dur.pop_front();
            if (pd == 0) begin
              free_at = e + 1;
            end else begin
              set_at  = e + 1;
              set_hp  = 32'(tone_tab[pc]);
              set_ten = (tone_tab[pc] != 0);
              clr_at  = set_at + pd * BEAT;
              nd_at   = clr_at + GAPC;
              free_at = nd_at + 1;
            end
          end
          if (in_valid && pre < DEPTH) begin
            m_code.push_back(int'(in_code));
            m_dur.push_back(int'(in_dur));
          end
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge iclk);
      check("half_period", longint'(half_period), longint'(m_hp));
      check("tone_en", tone_en, m_ten);
      check("note_done", note_done, m_nd);
      check("busy", busy, (m_code.size() != 0) || (e < free_at));
      check("in_ready", in_ready, m_code.size() < DEPTH);
      if (note_done) nd_pulses++;
      if (tone_en) begin
        ten_cycles++;
        if (low_run != 0) last_low = low_run;
        low_run = 0;
      end else begin
        low_run++;
      end
    end
  endtask

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  task automatic push(input int c, input int d, output int waited);
    waited   = 0;
    in_valid = 1'b1;
    in_code  = 4'(c);
    in_dur   = 4'(d);
    while (!in_ready && waited < 300) begin tick(); waited++; end
    if (waited >= 300) check("push_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 1000) begin tick(); n++; end
    check(name, busy, 0);
  endtask

  task automatic wait_tone(input string name, input logic lvl, input logic [31:0] hp, input logic use_hp);
    int n = 0;
    while (!(tone_en == lvl && (!use_hp || half_period == hp)) && n < 500) begin tick(); n++; end
    check(name, n < 500, 1);
  endtask

  initial begin
    int w, nd0, tc0;
    fork
      monitor();
    join_none
    #23 irst_n = 1'b1;
    tick();
    check("reset_in_ready", in_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_hp", half_period, 0);

    // single tone, 2 beats
    nd0 = nd_pulses; tc0 = ten_cycles;
    push(6, 2, w);
    check("t1_busy", busy, 1);
    tick();        check("t1_e1_ten", tone_en, 0);
    tick();        check("t1_e2_hp", half_period, 56818); check("t1_e2_ten", tone_en, 1);
    repeat (8) tick();
    check("t1_ten_off", tone_en, 0); check("t1_hp_hold", half_period, 56818);
    repeat (2) tick();
    check("t1_note_done", note_done, 1); check("t1_busy_nd", busy, 1);
    tick();
    check("t1_nd_off", note_done, 0); check("t1_idle", busy, 0);
    check("t1_ten_cycles", ten_cycles - tc0, 8); check("t1_nd_count", nd_pulses - nd0, 1);

    // queue fill and backpressure
    nd0 = nd_pulses; tc0 = ten_cycles;
    for (int i = 1; i <= 5; i++) push(i, 1, w);
    check("t2_full", in_ready, 0);
    push(6, 1, w);
    check("t2_blocked", w > 0, 1);
    wait_idle("t2_idle");
    check("t2_nd_count", nd_pulses - nd0, 6);
    check("t2_ten_cycles", ten_cycles - tc0, 24);
    check("t2_low_gap", last_low, GAPC + 2);

    // rests
    nd0 = nd_pulses; tc0 = ten_cycles;
    push(0, 1, w); push(9, 1, w); push(1, 1, w);
    wait_idle("t3_idle");
    check("t3_ten_cycles", ten_cycles - tc0, 4);
    check("t3_nd_count", nd_pulses - nd0, 3);
    check("t3_hp_hold", half_period, 95556);

    // zero-duration entry is skipped
    nd0 = nd_pulses;
    push(3, 0, w); push(8, 1, w);
    tick(); check("t4_e2_hp", half_period, 95556); check("t4_e2_ten", tone_en, 0);
    tick(); check("t4_e3_hp", half_period, 47778); check("t4_e3_ten", tone_en, 1);
    wait_idle("t4_idle");
    check("t4_nd_count", nd_pulses - nd0, 1);

    // stop mid-play with a simultaneous push
    push(1, 2, w); push(2, 2, w); push(3, 2, w);
    wait_tone("t5_second_note", 1'b1, 32'd85131, 1'b1);
    tick(); tick();
    stop = 1'b1; in_valid = 1'b1; in_code = 4'd5; in_dur = 4'd1;
    tick();
    stop = 1'b0; in_valid = 1'b0;
    check("t5_hp", half_period, 0); check("t5_ten", tone_en, 0);
    check("t5_busy", busy, 0); check("t5_ready", in_ready, 1); check("t5_nd", note_done, 0);
    nd0 = nd_pulses; tc0 = ten_cycles;
    repeat (40) tick();
    check("t5_no_nd", nd_pulses - nd0, 0); check("t5_no_tone", ten_cycles - tc0, 0);
    check("t5_still_idle", busy, 0);

    // asynchronous reset during the gap
    push(7, 1, w);
    wait_tone("t6_tone_on", 1'b1, '0, 1'b0);
    wait_tone("t6_tone_off", 1'b0, '0, 1'b0);
    #3 irst_n = 1'b0;
    #1;
    check("t6_rst_hp", half_period, 0); check("t6_rst_ten", tone_en, 0);
    check("t6_rst_busy", busy, 0); check("t6_rst_nd", note_done, 0);
    #3 irst_n = 1'b1;
    tick();
    push(2, 1, w);
    tick(); check("t6_e1_ten", tone_en, 0);
    tick(); check("t6_e2_hp", half_period, 85131); check("t6_e2_ten", tone_en, 1);
    wait_idle("t6_idle");

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      in_valid = ($urandom_range(0, 2) == 0);
      in_code  = 4'($urandom_range(0, 15));
      in_dur   = 4'($urandom_range(0, 5));
      stop     = ($urandom_range(0, 150) == 0);
      tick();
    end
    in_valid = 1'b0;
    stop     = 1'b0;
    wait_idle("rand_idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
